// File: rtl/i2c_master_n.sv
// I2C write-only master: START, address+W, MESSAGE_LENGTH/8 data bytes MSB-first, STOP.
// Each SCL bit cell is four quarters of CLK_DIV clocks; ACK slots abort the frame on NACK.
module i2c_master_n #(
  parameter int MESSAGE_LENGTH = 8,
  parameter int CLK_DIV        = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [6:0]                addr,
  input  logic [MESSAGE_LENGTH-1:0] data,
  input  logic                      sda_in,
  output logic                      sda_oe,
  output logic                      scl,
  output logic                      busy,
  output logic                      done,
  output logic                      nack
);

  localparam int BYTES = MESSAGE_LENGTH / 8;
  localparam int QW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, DONE
  } state_t;

  state_t                    state;
  logic [QW-1:0]             qcnt;
  logic [1:0]                quarter;
  logic [2:0]                bit_idx;
  logic [3:0]                byte_idx;
  logic [7:0]                asr;
  logic [MESSAGE_LENGTH-1:0] dsr;
  logic                      tick;

  assign tick = (qcnt == QW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      qcnt     <= '0;
      quarter  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      asr      <= '0;
      dsr      <= '0;
      sda_oe   <= 1'b0;
      scl      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      nack     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          qcnt    <= '0;
          quarter <= '0;
          if (start) begin
            asr      <= {addr, 1'b0};
            dsr      <= data;
            busy     <= 1'b1;
            nack     <= 1'b0;
            bit_idx  <= '0;
            byte_idx <= '0;
            state    <= START;
          end
        end
        DONE: state <= IDLE;
        default: begin
          if (!tick) begin
            qcnt <= qcnt + 1'b1;
          end else begin
            qcnt    <= '0;
            quarter <= quarter + 2'd1;
            case (state)
              START: begin
                if (quarter == 2'd0) begin
                  sda_oe <= 1'b1;
                end else begin
                  quarter <= '0;
                  scl     <= 1'b0;
                  sda_oe  <= ~asr[7];
                  state   <= ADDR;
                end
              end
              STOP: begin
                case (quarter)
                  2'd0:    scl <= 1'b1;
                  2'd1:    sda_oe <= 1'b0;
                  default: begin
                    quarter <= '0;
                    state   <= DONE;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                  end
                endcase
              end
              default: begin
                // Bit cell: SCL rises after q1, ACK sampled at end of q2, next bit set as SCL falls.
                if (quarter == 2'd1) scl <= 1'b1;
                if (quarter == 2'd2 && (state == ADDR_ACK || state == DATA_ACK) && sda_in)
                  nack <= 1'b1;
                if (quarter == 2'd3) begin
                  scl     <= 1'b0;
                  bit_idx <= bit_idx + 3'd1;
                  case (state)
                    ADDR: begin
                      asr <= {asr[6:0], 1'b0};
                      if (bit_idx == 3'd7) begin
                        sda_oe <= 1'b0;
                        state  <= ADDR_ACK;
                      end else begin
                        sda_oe <= ~asr[6];
                      end
                    end
                    DATA: begin
                      dsr <= {dsr[MESSAGE_LENGTH-2:0], 1'b0};
                      if (bit_idx == 3'd7) begin
                        sda_oe <= 1'b0;
                        state  <= DATA_ACK;
                      end else begin
                        sda_oe <= ~dsr[MESSAGE_LENGTH-2];
                      end
                    end
                    ADDR_ACK: begin
                      bit_idx <= '0;
                      if (nack) begin
                        sda_oe <= 1'b1;
                        state  <= STOP;
                      end else begin
                        sda_oe <= ~dsr[MESSAGE_LENGTH-1];
                        state  <= DATA;
                      end
                    end
                    DATA_ACK: begin
                      bit_idx <= '0;
                      if (nack || byte_idx == 4'(BYTES - 1)) begin
                        sda_oe <= 1'b1;
                        state  <= STOP;
                      end else begin
                        byte_idx <= byte_idx + 4'd1;
                        sda_oe   <= ~dsr[MESSAGE_LENGTH-1];
                        state    <= DATA;
                      end
                    end
                    default: ;
                  endcase
                end
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: doc/i2c_master_n.md
Name: i2c_master_n

Overview:
- Parametrised successor to the single-byte I2C master.
- Performs one complete I2C write frame per request: START, 7-bit address plus W bit, MESSAGE_LENGTH/8 data bytes MSB-first, STOP.
- Adds a programmable SCL divider, a start/busy/done handshake, open-drain SDA with ACK sampling, and NACK abort.
- Sits between the controller logic and the board I2C pins.

Parameters:
- MESSAGE_LENGTH, 8, payload bits per frame. Must be a multiple of 8, range 8..64.
- CLK_DIV, 4, clk cycles per SCL quarter-period. Minimum 1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; accepted only when busy=0.
- addr  input  7  target address; latched on accept.
- data  input  MESSAGE_LENGTH  payload; latched on accept; byte [MSB:MSB-7] is sent first.
- sda_in  input  1  sampled SDA line level.
- sda_oe  output  1  1 = pull SDA low, 0 = release (line goes high).
- scl  output  1  SCL level.
- busy  output  1  high from accept until done.
- done  output  1  one-cycle pulse at end of frame.
- nack  output  1  set when a NACK is sampled; held until the next accept.

Behaviour:
- Reset: on a clk edge with reset=1, sda_oe=0, scl=1, busy=0, done=0, nack=0, state=IDLE, quarter and bit counters cleared.
  - Reset takes priority mid-frame: lines are released on that edge, and no STOP is generated.
- Timebase:
  - Quarter counter counts 0..CLK_DIV-1; a quarter tick occurs when it wraps.
  - All state, SCL and SDA changes happen only on quarter ticks, except accept.
- Accept: in IDLE with start=1, the next edge latches addr and data, sets busy=1, clears nack, and enters START.
  - start while busy=1 is ignored. There is no queueing.
- States and transitions:
  - IDLE: scl=1, sda_oe=0.
  - START, 2 quarters: q0 SDA released, SCL high; q1 SDA low, SCL high. Then ADDR.
  - Bit cell, 4 quarters: q0 and q1 SCL low, with SDA set at the start of q0; q2 and q3 SCL high.
  - ADDR: 8 bit cells sending {addr, 1'b0} MSB-first. Then ADDR_ACK.
  - ADDR_ACK: 1 bit cell with SDA released; sda_in sampled at the end of q2.
    - 0 → DATA.
    - 1 → nack=1, then STOP.
  - DATA: 8 bit cells for the current byte. Then DATA_ACK.
  - DATA_ACK: same sampling as ADDR_ACK.
    - NACK → nack=1, then STOP.
    - ACK with more bytes remaining → DATA for the next byte.
    - ACK on the last byte → STOP.
  - STOP, 3 quarters: q0 SCL low, SDA low; q1 SCL high, SDA low; q2 SCL high, SDA released. Then DONE.
  - DONE: one cycle with done=1 and busy=0 asserted together, then IDLE.
- Frame length with B = MESSAGE_LENGTH/8 and all ACKs: (2 + 36 + 36·B + 3)·CLK_DIV cycles from accept to done, inclusive of the done cycle's preceding edge.
- Frame length on address NACK: (2 + 36 + 3)·CLK_DIV cycles.
- SDA never changes while SCL is high, except the START and STOP edges.

Test Plan:
- Basic write, defaults (CLK_DIV=4), addr=0x50, data=8'h5F, slave ACKs:
  - SDA bits sampled on SCL rise are 1010000 0 ack 01011111 ack.
  - done pulses 308 cycles after accept; nack=0.
- Address NACK, slave never pulls low, addr=0x21:
  - STOP follows the 9th clock and no data bits appear.
  - done pulses at cycle 164; nack=1 and held.
  - A new start clears nack.
- Multi-byte, MESSAGE_LENGTH=16, data=16'h95F0, all ACK:
  - Bytes 0x95 then 0xF0 observed.
  - done at (2+36+72+3)·4 = 452 cycles.
- NACK on the second data byte, MESSAGE_LENGTH=16:
  - STOP immediately after that ACK slot; nack=1.
  - done at (2+72+3)·4 + 36·4 = 452 cycles.
- start pulsed while busy with different addr/data:
  - Ignored; the frame still carries the original values; busy is not extended.
- reset asserted mid-DATA, then CLK_DIV=1 run with data=8'h0F:
  - On the reset edge: scl=1, sda_oe=0, busy=0, done=0.
  - The subsequent frame completes in 77 cycles with correct bits.
